// File: rtl/cpu_prog_ctrl.sv
// cpu_prog_ctrl: program store and execution sequencer for the 4-bit cpu core.
//   Holds a 16x8 program memory that is loaded byte-serially (ld_*). It returns
//   {opecode,imm} for the core fetch address, and it paces the core with a
//   one-cycle cpu_en strobe. The strobe runs in one of three modes: free-run
//   (prescaled by div_sel), single-step (step_req edge) or halted.
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   addr -> opecode/imm   combinational program read
//   cpu_en                core advance strobe
//   ld_start/valid/data   program load request and byte stream; ld_ready, ld_done
//   run_req/halt_req      enter free-run / return to idle (halt has top priority)
//   step_req, div_sel     single-step button level, run prescaler terminal value
//   running               high while free-running
//   bp_en/bp_addr/bp_hit  breakpoint; active only when CPU_BREAKPOINT_EN is defined
module cpu_prog_ctrl #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [3:0]       addr,
    output logic [3:0]       opecode,
    output logic [3:0]       imm,
    output logic             cpu_en,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    output logic             ld_ready,
    output logic             ld_done,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic [DIV_W-1:0] div_sel,
    output logic             running,
    input  logic             bp_en,
    input  logic [3:0]       bp_addr,
    output logic             bp_hit
);

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STEP
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wptr;
    logic [DIV_W-1:0]    r_cnt;
    logic                r_step_prev;
    logic                r_ld_done;
    logic                r_bp_hit;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_wptr_nxt;
    logic [DIV_W-1:0]    w_cnt_nxt;
    logic                w_mem_we;
    logic                w_ld_done_nxt;
    logic                w_bp_hit_nxt;
    logic                w_cpu_en_c;
    logic                w_tc;
    logic                w_step_edge;
    logic                w_bp_stop;

    assign w_tc        = (r_cnt == div_sel);
    assign w_step_edge = step_req & ~r_step_prev;

`ifdef CPU_BREAKPOINT_EN
    // Disarmed for the first terminal count of every run so a run can resume from a breakpoint.
    logic r_bp_armed;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_bp_armed <= 1'b0;
        end else if (r_state != S_RUN) begin
            r_bp_armed <= 1'b0;
        end else if (w_tc) begin
            r_bp_armed <= 1'b1;
        end
    end

    assign w_bp_stop = (r_state == S_RUN) && w_tc && r_bp_armed && bp_en && (addr == bp_addr);
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{bp_en, bp_addr};
    assign w_bp_stop   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, datapath controls and the run/step strobe
    always_comb begin
        w_state_nxt   = r_state;
        w_wptr_nxt    = r_wptr;
        w_cnt_nxt     = r_cnt;
        w_mem_we      = 1'b0;
        w_ld_done_nxt = 1'b0;
        w_bp_hit_nxt  = 1'b0;
        w_cpu_en_c    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!halt_req) begin
                    if (ld_start) begin
                        w_state_nxt = S_LOAD;
                        w_wptr_nxt  = '0;
                    end else if (w_step_edge) begin
                        w_state_nxt = S_STEP;
                    end else if (run_req) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_LOAD: begin
                if (halt_req) begin
                    w_state_nxt = S_IDLE;
                end else if (ld_valid) begin
                    w_mem_we   = 1'b1;
                    w_wptr_nxt = ADDR_W'(r_wptr + 1'b1);
                    if (r_wptr == ADDR_W'(DEPTH - 1)) begin
                        w_state_nxt   = S_IDLE;
                        w_ld_done_nxt = 1'b1;
                    end
                end
            end
            S_STEP: begin
                w_cpu_en_c  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (halt_req) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tc) begin
                    if (w_bp_stop) begin
                        w_state_nxt  = S_IDLE;
                        w_bp_hit_nxt = 1'b1;
                    end else begin
                        w_cpu_en_c = 1'b1;
                        w_cnt_nxt  = '0;
                    end
                end else begin
                    // Free increment: a div_sel lowered below cnt wraps through all-ones
                    w_cnt_nxt = DIV_W'(r_cnt + 1'b1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, edge detect and one-cycle status pulses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr      <= '0;
            r_cnt       <= '0;
            r_step_prev <= 1'b0;
            r_ld_done   <= 1'b0;
            r_bp_hit    <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_step_prev <= step_req;
            r_ld_done   <= w_ld_done_nxt;
            r_bp_hit    <= w_bp_hit_nxt;
        end
    end

    // Program store, cleared by reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[r_wptr] <= ld_data;
        end
    end

    assign {opecode, imm} = r_mem[addr];
    assign cpu_en         = w_cpu_en_c;
    assign ld_ready       = (r_state == S_LOAD);
    assign running        = (r_state == S_RUN);
    assign ld_done        = r_ld_done;
    assign bp_hit         = r_bp_hit;

endmodule

// File: tb/tb_cpu_prog_ctrl.sv
// Scoreboard bench for cpu_prog_ctrl: a mode-level reference model pushes the
// expected outputs of every cycle into a queue, and a negedge monitor pops and
// compares them. A few directed totals (strobe counts, read-back bytes) are
// checked against constants.
module tb_cpu_prog_ctrl;

    localparam int DIV_W = 4;
    localparam int MD_IDLE = 0, MD_LOAD = 1, MD_RUN = 2, MD_STEP = 3;

    typedef struct packed {
        logic       en;
        logic       rdy;
        logic       done;
        logic       run;
        logic       bph;
        logic [3:0] op;
        logic [3:0] im;
    } exp_t;

    logic             clk;
    logic             n_rst;
    logic [3:0]       addr;
    logic [3:0]       opecode;
    logic [3:0]       imm;
    logic             cpu_en;
    logic             ld_start;
    logic             ld_valid;
    logic [7:0]       ld_data;
    logic             ld_ready;
    logic             ld_done;
    logic             run_req;
    logic             halt_req;
    logic             step_req;
    logic [DIV_W-1:0] div_sel;
    logic             running;
    logic             bp_en;
    logic [3:0]       bp_addr;
    logic             bp_hit;

    cpu_prog_ctrl #(.DIV_W(DIV_W)) dut (
        .clk(clk), .n_rst(n_rst), .addr(addr), .opecode(opecode), .imm(imm),
        .cpu_en(cpu_en), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .div_sel(div_sel), .running(running), .bp_en(bp_en),
        .bp_addr(bp_addr), .bp_hit(bp_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   errors = 0;
    int   checks = 0;
    int   ticks  = 0;
    int   en_seen = 0;
    int   done_seen = 0;
    int   bph_seen = 0;
    exp_t q[$];

    // Reference model state
    int        m_mode;
    logic [7:0] m_mem [16];
    int        m_wptr;
    int        m_cnt;
    bit        m_prev;
    bit        m_done;
    bit        m_bph;
    bit        m_armed;
    bit        core;
    int        ip;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic bit m_tc();
        return m_cnt == int'(div_sel);
    endfunction

    function automatic bit m_bpstop();
`ifdef CPU_BREAKPOINT_EN
        return (m_mode == MD_RUN) && m_tc() && m_armed && bp_en && (addr == bp_addr);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = MD_IDLE;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_wptr = 0; m_cnt = 0; m_prev = 0; m_done = 0; m_bph = 0; m_armed = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.en   = (m_mode == MD_STEP) || ((m_mode == MD_RUN) && m_tc() && !halt_req && !m_bpstop());
        e.rdy  = (m_mode == MD_LOAD);
        e.done = m_done;
        e.run  = (m_mode == MD_RUN);
        e.bph  = m_bph;
        {e.op, e.im} = m_mem[addr];
        return e;
    endfunction

    task automatic model_update();
        bit edge_s, stop, tc;
        if (!n_rst) begin
            model_reset();
            return;
        end
        edge_s = step_req && !m_prev;
        stop   = m_bpstop();
        tc     = m_tc();
        m_done = 0;
        m_bph  = 0;
        case (m_mode)
            MD_IDLE: if (!halt_req) begin
                if (ld_start) begin m_mode = MD_LOAD; m_wptr = 0; end
                else if (edge_s) m_mode = MD_STEP;
                else if (run_req) begin m_mode = MD_RUN; m_cnt = 0; m_armed = 0; end
            end
            MD_LOAD: if (halt_req) m_mode = MD_IDLE;
                else if (ld_valid) begin
                    m_mem[m_wptr] = ld_data;
                    if (m_wptr == 15) begin m_mode = MD_IDLE; m_done = 1; end
                    m_wptr = (m_wptr + 1) % 16;
                end
            MD_STEP: m_mode = MD_IDLE;
            default: if (halt_req) m_mode = MD_IDLE;
                else if (tc) begin
                    if (stop) begin m_mode = MD_IDLE; m_bph = 1; end
                    else begin m_cnt = 0; m_armed = 1; end
                end else m_cnt = (m_cnt + 1) % (1 << DIV_W);
        endcase
        m_prev = step_req;
    endtask

    // One clock cycle: inputs were set by the caller just after the previous edge
    task automatic tick();
        exp_t e;
        if (core) addr = 4'(ip);
        if (!n_rst) model_reset();
        e = model_out();
        q.push_back(e);
        ticks++;
        @(posedge clk);
        model_update();
        if (core && e.en) ip = (ip + 1) % 16;
        #1;
    endtask

    task automatic quiet();
        ld_start = 0; ld_valid = 0; run_req = 0; halt_req = 0; step_req = 0;
    endtask

    // Monitor: compare DUT outputs with the oldest expectation, mid-cycle
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {cpu_en, ld_ready, ld_done, running, bp_hit, opecode, imm};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t: got en=%b rdy=%b done=%b run=%b bph=%b op=%h imm=%h expected en=%b rdy=%b done=%b run=%b bph=%b op=%h imm=%h",
                         $time, a.en, a.rdy, a.done, a.run, a.bph, a.op, a.im,
                         e.en, e.rdy, e.done, e.run, e.bph, e.op, e.im);
            end
            if (cpu_en === 1'b1) en_seen++;
            if (ld_done === 1'b1) done_seen++;
            if (bp_hit === 1'b1) bph_seen++;
        end
    end

    initial begin
        int base;
        int n;
        logic [7:0] d [7];
        logic [7:0] rd;
        n_rst = 0; addr = 0; ld_data = 0; div_sel = 0; bp_en = 0; bp_addr = 0;
        core = 0; ip = 0;
        quiet();
        model_reset();
        @(posedge clk); #1;

        // Reset state over random addresses
        for (int i = 0; i < 3; i++) begin addr = 4'($urandom); tick(); end
        n_rst = 1;
        tick();

        // Load 8'h30..8'h3F with random valid gaps
        base = done_seen;
        ld_start = 1; tick(); ld_start = 0;
        chk("load_ready", int'(ld_ready), 1);
        n = 0;
        while (n < 16) begin
            ld_valid = ($urandom_range(0, 2) != 0);
            ld_data  = ld_valid ? 8'(8'h30 + n) : 8'($urandom);
            tick();
            if (ld_valid) n++;
        end
        ld_valid = 0;
        addr = 4'd5; tick(); tick();
        chk("load_done_pulses", done_seen - base, 1);
        addr = 4'd5; #1;
        chk("read_addr5", int'({opecode, imm}), 8'h35);

        // Run, div_sel=2: strobes on RUN cycles 3,6,9; halt lands on terminal cycle 12
        div_sel = 2; base = en_seen;
        run_req = 1; tick(); run_req = 0;
        for (int i = 0; i < 11; i++) begin addr = 4'($urandom); tick(); end
        halt_req = 1; tick(); halt_req = 0;
        chk("halted_running", int'(running), 0);
        tick();
        chk("run_div2_strobes", en_seen - base, 3);

        // Run, div_sel=0: strobe every RUN cycle including the first
        div_sel = 0; base = en_seen;
        run_req = 1; tick(); run_req = 0;
        for (int i = 0; i < 5; i++) tick();
        halt_req = 1; tick(); halt_req = 0; tick();
        chk("run_div0_strobes", en_seen - base, 5);

        // Step: held button gives one step, a new press gives another
        base = en_seen;
        step_req = 1; for (int i = 0; i < 10; i++) tick();
        step_req = 0; tick(); tick();
        step_req = 1; for (int i = 0; i < 3; i++) tick();
        step_req = 0; tick(); tick();
        chk("step_strobes", en_seen - base, 2);

        // Priority: load wins over step edge and run
        ld_start = 1; run_req = 1; step_req = 1; tick(); quiet();
        chk("prio_load_ready", int'(ld_ready), 1);
        chk("prio_not_running", int'(running), 0);

        // Abort after 7 bytes
        base = done_seen;
        for (int i = 0; i < 7; i++) begin
            d[i] = 8'($urandom); ld_valid = 1; ld_data = d[i]; tick();
        end
        ld_valid = 0; halt_req = 1; tick(); halt_req = 0; tick(); tick();
        chk("abort_no_done", done_seen - base, 0);
        addr = 0; #1; rd = {opecode, imm}; chk("abort_new_0", int'(rd), int'(d[0]));
        addr = 6; #1; rd = {opecode, imm}; chk("abort_new_6", int'(rd), int'(d[6]));
        addr = 7; #1; rd = {opecode, imm}; chk("abort_old_7", int'(rd), 8'h37);
        addr = 15; #1; rd = {opecode, imm}; chk("abort_old_15", int'(rd), 8'h3F);

        // div_sel lowered below cnt mid-count: counter wraps
        div_sel = 5; run_req = 1; tick(); run_req = 0;
        for (int i = 0; i < 4; i++) tick();
        div_sel = 1;
        for (int i = 0; i < 24; i++) tick();
        halt_req = 1; tick(); halt_req = 0; tick();

`ifdef CPU_BREAKPOINT_EN
        // Breakpoint at addr 4 with the core ip counting
        core = 1; ip = 0; bp_en = 1; bp_addr = 4; div_sel = 0; base = bph_seen;
        run_req = 1; tick(); run_req = 0;
        n = 0;
        while (bph_seen == base && n < 30) begin tick(); n++; end
        chk("bp_seen", bph_seen - base, 1);
        chk("bp_stop_ip", ip, 4);
        run_req = 1; tick(); run_req = 0;
        tick(); tick();
        halt_req = 1; tick(); halt_req = 0; tick();
        chk("bp_resume_ip", ip, 6);
        core = 0; bp_en = 0;
`endif

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if (k % 100 == 0) core = 1'($urandom_range(0, 1));
            halt_req = ($urandom_range(0, 19) == 0);
            ld_start = ($urandom_range(0, 39) == 0);
            run_req  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) step_req = ~step_req;
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = 8'($urandom);
            if ($urandom_range(0, 29) == 0) div_sel = DIV_W'($urandom_range(0, 3));
            bp_en    = 1'($urandom_range(0, 1));
            bp_addr  = 4'($urandom);
            if (!core) addr = 4'($urandom);
            tick();
        end
        quiet(); core = 0; bp_en = 0;

        // Reset mid-run clears everything including the program store
        div_sel = 1; run_req = 1; tick(); run_req = 0;
        tick(); tick();
        n_rst = 0; tick(); tick();
        n_rst = 1;
        for (int i = 0; i < 16; i++) begin addr = 4'(i); tick(); end
        addr = 4'd9; #1;
        chk("reset_clears_mem", int'({opecode, imm}), 0);

        @(negedge clk); #1;
        chk("queue_drained", q.size(), 0);
        chk("all_cycles_compared", checks - 0 >= ticks ? 1 : 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
